// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Round-robin arbiter producing the 2-bit select for a 4:1 mux.
//   Four requesters compete and one grant is active at a time.
//   A grant ends when the owner raises done or drops its request.
//   With the timeout option it also ends after HOLD_MAX cycles.
//   Priority then rotates to the index just above the last owner.
//
// Optional feature:
//   `define MUX_SEL_ARB_TIMEOUT_EN turns on the hold-limit release.
//   This limit uses the 8-bit hold_cnt.
//   When the macro is undefined, hold_cnt is not built.
//
// Parameters:
//   HOLD_MAX  Maximum consecutive grant cycles when the timeout is built (1..255).
//
// Ports:
//   clk    input   1  rising-edge clock
//   rst    input   1  asynchronous active-high reset
//   req    input   4  request lines, req[i] asks for mux input i
//   done   input   1  current grantee finished (only looked at while granting)
//   sel    output  2  registered index of the granted input; held while idle
//   gnt    output  4  registered one-hot grant, zero when nothing is granted
//   valid  output  1  high while a grant is active

module mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid
);

    // state | meaning
    // IDLE  | no grant active; arbitrate on the next edge if any req is set
    // GRANT | gnt/sel/valid name the current owner; wait for a release cause
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mux_sel_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       release_now;

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt;
`endif

    // Rotating search: the first set request at or above ptr (mod 4) wins.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Several causes in one cycle collapse into one release.
    always_comb begin
        release_now = done || !req[sel];
`ifdef MUX_SEL_ARB_TIMEOUT_EN
        if (hold_cnt == HOLD_LAST) begin
            release_now = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= 2'd0;
            gnt      <= 4'b0000;
            valid    <= 1'b0;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel      <= win;
                        gnt      <= 4'b0001 << win;
                        valid    <= 1'b1;
                        state    <= GRANT;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // sel stays put so the mux output is stable while idle.
                        gnt      <= 4'b0000;
                        valid    <= 1'b0;
                        ptr      <= sel + 2'd1;
                        state    <= IDLE;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end else begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
                        if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that produces the 2-bit select for the team's 4:1 multiplexer. It sits directly upstream of the mux: four requesters each raise a request line, the arbiter grants one at a time and drives `sel` so the mux forwards the granted source. The grant is held until the owner signals completion, drops its request, or (optionally) exceeds a hold limit. Priority then rotates to the next index.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive GRANT cycles before forced release. Legal range 1..255. Used only when the timeout feature is compiled in.

- `clk`  input  1  single clock; rising-edge active.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request lines; `req[i]` requests mux input i (0=a, 1=b, 2=c, 3=d).
- `done`  input  1  current grantee finished; sampled only in GRANT.
- `sel`  output  2  registered binary index of the granted input; drives the mux `sel`.
- `gnt`  output  4  registered one-hot grant; all zero when nothing is granted.
- `valid`  output  1  high while a grant is active (`gnt != 0`).

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 2-bit priority pointer `ptr`.
  - Hold counter `hold_cnt`, 8 bits wide.
- Reset (asynchronous, immediate in every state): state=IDLE, `ptr`=0, `hold_cnt`=0, `sel`=2'b00, `gnt`=4'b0000, `valid`=0.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise, search `req` starting at index `ptr` and going upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3); the first set bit wins as index w.
  - At that edge: `sel`<=w, `gnt`<=1<<w, `valid`<=1, `hold_cnt`<=0, state<=GRANT.
- GRANT: the release condition R is any of the following, sampled at the edge:
  - `done`=1;
  - `req[sel]`=0;
  - with the timeout feature compiled in, `hold_cnt`==HOLD_MAX-1.
- If R is false: `hold_cnt`<=`hold_cnt`+1 (saturating at 255), all outputs unchanged.
- If R is true:
  - `gnt`<=0, `valid`<=0, state<=IDLE, `ptr`<=(`sel`+1) mod 4 (2-bit wrap), `hold_cnt`<=0.
  - Several release causes in the same cycle produce exactly one release.
- `sel` is never changed on release or in IDLE. It keeps the last granted index so the mux output stays stable while `valid`=0.
- In GRANT, changes on `req` bits other than `req[sel]` are ignored.
- `done` is ignored in IDLE.
- Invariant: `valid` == |`gnt`, and `gnt`, when nonzero, == 1<<`sel`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request to grant latency is 1 edge: `req` sampled high at edge k (state IDLE) gives `gnt`/`sel`/`valid` valid after edge k.
- Release latency is 1 edge: R sampled true at edge k gives `valid`=0 after edge k.
- There is one mandatory bubble cycle (IDLE) between consecutive grants.
  - Minimum grant period is 2 cycles per grant under continuous contention.
  - With all four requesting continuously and releasing after 1 cycle, grant order is 0,1,2,3,0,...
- With the timeout feature, a grant lasts at most HOLD_MAX cycles with `valid`=1.
- Reset asserted mid-grant clears `gnt`/`valid` immediately, without waiting for a clock. After reset deasserts, arbitration restarts from index 0.

## Configuration
- Macro `MUX_SEL_ARB_TIMEOUT_EN`.
- Defined: the `hold_cnt` comparison against HOLD_MAX is part of R, so a single requester cannot starve the others.
- Undefined: the timeout term is removed from R, and `hold_cnt` and its logic are not built. The grant lasts until `done` or until `req[sel]` drops, with no upper bound.

## Test plan
- Reset check: assert `rst` with `req`=4'b1111 -> `sel`=0, `gnt`=0, `valid`=0 immediately and for as long as reset is held.
- Single requester: `req`=4'b0100 in IDLE -> after next edge `gnt`=4'b0100, `sel`=2, `valid`=1. Pulse `done` for one cycle -> `valid`=0 after that edge, `sel` stays 2, `ptr`=3.
- Rotation fairness: `req`=4'b1111 held, `done` pulsed every GRANT cycle -> `sel` sequence 0,1,2,3,0 with `valid` alternating 1,0.
- Request drop and simultaneous causes: during a grant to index 1, drop `req[1]` and raise `done` in the same cycle -> exactly one release, next grant goes to the next set index above 1 (with `req`=4'b1001 remaining -> index 3).
- Timeout (macro defined, HOLD_MAX=4): `req`=4'b0011 held, `done`=0 -> `gnt`=4'b0001 for exactly 4 cycles, 1 bubble, then `gnt`=4'b0010. With the macro undefined, the same stimulus keeps `gnt`=4'b0001 indefinitely.
- Reset mid-grant: assert `rst` asynchronously while `gnt`=4'b1000 -> `gnt`=0 and `valid`=0 before the next edge. After release with `req`=4'b1000, index 3 is granted on the first edge.
